instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage sitting directly downstream of the branching unit. It accepts the next program counter, issues a request/acknowledge read to instruction memory, and holds the returned word in an instruction register for the decoder. It supports downstream stall, mid-fetch redirect with flush of the stale word, and a bounded-wait timeout fault.

## Interface
- ADDR_W, 32, program counter / memory address width
- DATA_W, 32, instruction word width
- TIMEOUT, 16, maximum FETCH cycles without ack before fault (≥2)
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- pc_in  input  ADDR_W  next PC from branching unit
- pc_load  input  1  pc_in is valid this cycle (single-cycle strobe)
- imem_req  output  1  read request to instruction memory
- imem_addr  output  ADDR_W  read address, equals pc_cur while imem_req=1
- imem_ack  input  1  read data valid this cycle; ignored unless imem_req=1
- imem_rdata  input  DATA_W  instruction word, sampled when imem_ack=1
- stall  input  1  decoder cannot accept ir_out this cycle
- pc_cur  output  ADDR_W  PC of the word being fetched/held
- ir_out  output  DATA_W  instruction register
- ir_valid  output  1  ir_out/pc_cur hold a valid fetched instruction
- fault  output  1  sticky memory timeout flag

## Operation
- States: IDLE, FETCH, HOLD, FAULT. All outputs registered.
- IDLE: imem_req=0, ir_valid=0. pc_load=1 → pc_cur←pc_in, wait_cnt←0, go FETCH.
- FETCH: imem_req=1, imem_addr=pc_cur.
  - pc_load=1 with no ack: redirect_pend←1, redirect_pc←pc_in; stay FETCH (request address not changed mid-transaction).
  - imem_ack=1 and no redirect pending (and no pc_load this cycle): ir_out←imem_rdata, ir_valid←1, go HOLD.
  - imem_ack=1 with redirect pending or pc_load this cycle: discard imem_rdata (ir_out unchanged), pc_cur←newest redirect pc (pc_load value takes priority over redirect_pc), clear redirect_pend, wait_cnt←0, stay FETCH; imem_req drops for exactly one cycle before the new request.
  - No ack: wait_cnt+1; wait_cnt = TIMEOUT−1 with no ack → fault←1, go FAULT.
- HOLD: ir_valid=1, imem_req=0.
  - stall=1: hold ir_out, pc_cur; a pc_load here is captured into redirect_pend/redirect_pc.
  - stall=0 with pc_load=1 or redirect_pend=1: word consumed; pc_cur←new pc, ir_valid←0, go FETCH.
  - stall=0 otherwise: word consumed; ir_valid←0, go IDLE.
- FAULT: imem_req=0, ir_valid=0, fault=1; absorbing until rst. pc_load ignored.
- wait_cnt width clog2(TIMEOUT); never wraps (leaves FETCH first).
- rst overrides everything in the same edge, including mid-transaction; a late imem_ack after reset is ignored (state IDLE).

## Timing
- Reset values: imem_req=0, imem_addr=0, pc_cur=0, ir_out=0, ir_valid=0, fault=0, redirect_pend=0, state IDLE.
- pc_load at edge t (IDLE) → imem_req=1 from cycle t+1.
- imem_ack sampled at edge k → ir_valid=1 and imem_req=0 from cycle k+1.
- Zero-wait memory (ack in first FETCH cycle): pc_load to ir_valid = 2 cycles.
- Consumption: ir_valid deasserts the cycle after an edge with ir_valid=1, stall=0.
- Back-to-back: HOLD consume + pc_load → imem_req=1 next cycle; sustained throughput one instruction per 2 cycles with zero-wait memory.
- Timeout: FAULT entered at the edge ending the TIMEOUT-th consecutive un-acked FETCH cycle; fault=1 from the next cycle.

## Test plan
- Reset then pc_load, pc_in=0x10, memory acks same cycle with 0xDEADBEEF → imem_addr=0x10, ir_valid=1 two cycles after pc_load, ir_out=0xDEADBEEF, pc_cur=0x10.
- Memory with 3-cycle ack latency, stall=1 for 4 cycles after ir_valid → imem_req high exactly 3 cycles; ir_out/pc_cur stable through stall; ir_valid drops one cycle after stall=0.
- Fetch 0x20, pc_load pc_in=0x40 during wait, ack returns 0x11111111 → word discarded, ir_valid stays 0, one req-low cycle, then imem_addr=0x40; ack 0x22222222 → ir_out=0x22222222, pc_cur=0x40.
- HOLD with stall=0 and pc_load pc_in=0x44 same cycle → ir_valid=0, imem_req=1, imem_addr=0x44 next cycle.
- TIMEOUT=4, no ack → fault=1 after 4 FETCH cycles, imem_req=0; further pc_load ignored; rst clears fault, state IDLE.
- rst asserted in FETCH, imem_ack arrives the following cycle → all outputs at reset values, ir_valid stays 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: loads the next PC, runs a req/ack read to instruction
// memory, and holds the returned word for the decoder. Supports stall, redirect and timeout.
//
// state | meaning
// IDLE  | no fetch in progress, waiting for pc_load
// FETCH | request outstanding (or one-cycle request gap after a discarded word)
// HOLD  | ir_out holds a valid word until the decoder consumes it
// FAULT | memory never answered; absorbing until rst
module instr_fetch #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_load,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc_cur,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  output logic              fault
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              redirect_pend;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] new_pc;

  // A pc_load arriving in the same cycle is newer than any pending redirect.
  assign new_pc    = pc_load ? pc_in : redirect_pc;
  assign imem_addr = pc_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      imem_req      <= 1'b0;
      pc_cur        <= '0;
      ir_out        <= '0;
      ir_valid      <= 1'b0;
      fault         <= 1'b0;
      wait_cnt      <= '0;
      redirect_pend <= 1'b0;
      redirect_pc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_load) begin
            pc_cur        <= pc_in;
            wait_cnt      <= '0;
            redirect_pend <= 1'b0;
            imem_req      <= 1'b1;
            state         <= FETCH;
          end
        end
        FETCH: begin
          if (!imem_req) begin
            // Gap cycle after a discarded word: nothing in flight, so a new PC lands directly.
            if (pc_load) pc_cur <= pc_in;
            imem_req <= 1'b1;
            wait_cnt <= '0;
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            if (pc_load || redirect_pend) begin
              pc_cur        <= new_pc;
              redirect_pend <= 1'b0;
              wait_cnt      <= '0;
            end else begin
              ir_out   <= imem_rdata;
              ir_valid <= 1'b1;
              state    <= HOLD;
            end
          end else if (wait_cnt == CNT_LAST) begin
            fault         <= 1'b1;
            imem_req      <= 1'b0;
            redirect_pend <= 1'b0;
            state         <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (pc_load) begin
              redirect_pend <= 1'b1;
              redirect_pc   <= pc_in;
            end
          end
        end
        HOLD: begin
          if (stall) begin
            if (pc_load) begin
              redirect_pend <= 1'b1;
              redirect_pc   <= pc_in;
            end
          end else if (pc_load || redirect_pend) begin
            pc_cur        <= new_pc;
            redirect_pend <= 1'b0;
            ir_valid      <= 1'b0;
            imem_req      <= 1'b1;
            wait_cnt      <= '0;
            state         <= FETCH;
          end else begin
            ir_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        FAULT: begin
          fault <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
